// File: rtl/alu_pkg.sv
// Shared ALU definitions: adder sizing, sum-with-carry
// type and the signed-overflow helper used by the add path.
package alu_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 4;
    localparam int ADDER_WIDTH_MIN     = 1;
    localparam int ADDER_WIDTH_MAX     = 32;

    // Sum with carry-out in the top bit, as consumed by the ALU mux.
    typedef logic [ADDER_WIDTH_DEFAULT:0] add_sum_t;

    // Registered adder result as one bundle.
    typedef struct packed {
        logic                           valid;
        logic                           cout;
        logic                           ovf;
        logic [ADDER_WIDTH_DEFAULT-1:0] s;
    } add_res_t;

    // Two's complement overflow: like-signed operands whose
    // sum lands with the other sign.
    function automatic logic add_ovf(
        input logic msb_a,
        input logic msb_b,
        input logic msb_s
    );
        return (msb_a == msb_b) && (msb_s != msb_a);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the ripple cell of the adder chain.
// Purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out,
// signed overflow and a one-cycle valid strobe.
module adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    assign w_carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rc
            full_adder u_fa (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (w_carry[gi]),
                .s  (w_sum[gi]),
                .co (w_carry[gi+1])
            );
        end
    endgenerate

    assign w_ovf = add_ovf(a[MSB], b[MSB], w_sum[MSB]);

    // Valid strobe: one cycle per accepted operand set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

    // Result registers load only on in_valid, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (in_valid) begin
            r_s    <= w_sum;
            r_cout <= w_carry[WIDTH];
            r_ovf  <= w_ovf;
        end
    end

    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: WIDTH=4 directed and exhaustive,
// WIDTH=8 random sweep.
module tb_adder;

    typedef struct {
        string       tag;
        logic [31:0] e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic [3:0] s4;
    logic       cout4, ovf4, ov4;

    logic       v8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] s8;
    logic       cout8, ovf8, ov8;

    int n_vec = 0;
    int n_err = 0;

    exp_t q4[$];
    exp_t q8[$];

    logic [3:0] m4_s = '0;
    logic       m4_c = 1'b0, m4_o = 1'b0;
    logic [7:0] m8_s = '0;
    logic       m8_c = 1'b0, m8_o = 1'b0;

    adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .s         (s4),
        .cout      (cout4),
        .ovf       (ovf4),
        .out_valid (ov4)
    );

    adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .s         (s8),
        .cout      (cout8),
        .ovf       (ovf8),
        .out_valid (ov8)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs4();
        return {21'b0, ov4, cout4, ovf4, 4'b0, s4};
    endfunction

    function automatic logic [31:0] obs8();
        return {21'b0, ov8, cout8, ovf8, s8};
    endfunction

    // Drive one WIDTH=4 cycle and push the expected outputs.
    task automatic drv4(
        input string      tag,
        input logic       v,
        input logic [3:0] ia,
        input logic [3:0] ib,
        input logic       ic
    );
        logic [4:0] full;
        exp_t       x;
        @(negedge clk);
        v4 = v; a4 = ia; b4 = ib; cin4 = ic;
        if (v) begin
            full = {1'b0, ia} + {1'b0, ib} + {4'b0, ic};
            m4_s = full[3:0];
            m4_c = full[4];
            m4_o = (ia[3] == ib[3]) && (m4_s[3] != ia[3]);
        end
        x.tag = tag;
        x.e   = {21'b0, v, m4_c, m4_o, 4'b0, m4_s};
        q4.push_back(x);
    endtask

    task automatic drv8(
        input string      tag,
        input logic       v,
        input logic [7:0] ia,
        input logic [7:0] ib,
        input logic       ic
    );
        logic [8:0] full;
        exp_t       x;
        @(negedge clk);
        v8 = v; a8 = ia; b8 = ib; cin8 = ic;
        if (v) begin
            full = {1'b0, ia} + {1'b0, ib} + {8'b0, ic};
            m8_s = full[7:0];
            m8_c = full[8];
            m8_o = (ia[7] == ib[7]) && (m8_s[7] != ia[7]);
        end
        x.tag = tag;
        x.e   = {21'b0, v, m8_c, m8_o, m8_s};
        q8.push_back(x);
    endtask

    // Hold reset for n cycles with live inputs; outputs must stay clear.
    task automatic rst_pulse(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        v4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
        #1;
        chk("rst_async4", obs4(), 32'h0);
        chk("rst_async8", obs8(), 32'h0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom);
            cin4 = 1'($urandom);
            v8 = 1'b1; a8 = 8'($urandom);
            #1;
            chk("rst_hold4", obs4(), 32'h0);
            chk("rst_hold8", obs8(), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v4 = 1'b0; v8 = 1'b0;
        m4_s = '0; m4_c = 1'b0; m4_o = 1'b0;
        m8_s = '0; m8_c = 1'b0; m8_o = 1'b0;
    endtask

    // Compare each DUT against its scoreboard just after the edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q4.size() != 0) begin
            x = q4.pop_front();
            chk(x.tag, obs4(), x.e);
        end
        if (q8.size() != 0) begin
            x = q8.pop_front();
            chk(x.tag, obs8(), x.e);
        end
    end

    initial begin
        rst_pulse(4);

        drv4("first",  1, 4'b0001, 4'b0001, 0);
        drv4("cout",   1, 4'b1010, 4'b0110, 0);
        drv4("idle_a", 0, 4'b0000, 4'b0000, 0);
        $display("1010 + 0110 = %b %b", cout4, s4);
        drv4("wrap1",  1, 4'b1111, 4'b0000, 1);
        drv4("wrap2",  1, 4'b1111, 4'b1111, 1);
        drv4("ovf_p",  1, 4'b0111, 4'b0001, 0);
        drv4("ovf_n",  1, 4'b1000, 4'b1000, 0);
        drv4("ovf_ci", 1, 4'b0111, 4'b0000, 1);
        drv4("b2b_1",  1, 4'b0011, 4'b0100, 0);
        drv4("b2b_2",  1, 4'b0101, 4'b0101, 0);
        drv4("b2b_3",  1, 4'b1100, 4'b0011, 0);
        drv4("hold1",  0, 4'bxxxx, 4'bxxxx, 1'bx);
        drv4("hold2",  0, 4'b0001, 4'b0001, 0);

        drv4("pre_rst", 1, 4'b0110, 4'b0011, 0);
        rst_pulse(2);
        drv4("post_rst", 1, 4'b0010, 4'b0011, 1);
        drv4("post_idle", 0, 4'b1111, 4'b1111, 1);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int c = 0; c < 2; c++) begin
                    drv4("exh", 1, 4'(i), 4'(j), 1'(c));
                end
            end
        end
        drv4("exh_end", 0, 4'b0000, 4'b0000, 0);

        drv8("w8_max", 1, 8'hFF, 8'h01, 0);
        drv8("w8_ovf", 1, 8'h7F, 8'h01, 0);
        for (int k = 0; k < 300; k++) begin
            drv8("w8_rand", ($urandom_range(0, 7) != 0),
                 8'($urandom), 8'($urandom), 1'($urandom));
        end
        drv8("w8_end", 0, 8'h00, 8'h00, 0);

        @(negedge clk);
        @(negedge clk);
        if (q4.size() != 0 || q8.size() != 0)
            chk("sb_drain", 32'(q4.size() + q8.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
